// File: rtl/instr_prefetch_queue_pkg.sv
// rtl/instr_prefetch_queue_pkg.sv - shared processor constants for the fetch stage
package instr_prefetch_queue_pkg;

  // Word and address widths shared with the datapath PC and IR registers
  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  // Reset vector, also loaded by the datapath PC register
  localparam logic [ADDR_W-1:0] PROC_RESET_PC = 16'h0000;

  // Width of an occupancy counter able to hold 0..depth inclusive
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// rtl/instr_prefetch_queue_if.sv - imem request/response and instruction handshake bundle
interface instr_prefetch_queue_if
  import instr_prefetch_queue_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = WORD_W,
  parameter int CW = count_width(4)
);

  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          instr_valid;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;
  logic [CW-1:0] q_count;

  // Prefetch queue side
  modport master (
    output imem_req, imem_addr, instr_valid, instr_data, instr_pc, q_count,
    input  imem_rdata, redirect, redirect_pc, instr_ready
  );

  // Memory / control unit side
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_data, instr_pc, q_count,
    output imem_rdata, redirect, redirect_pc, instr_ready
  );

endinterface

// File: rtl/instr_prefetch_queue_prefetch_fifo.sv
// rtl/instr_prefetch_queue_prefetch_fifo.sv - small register FIFO of {instruction, pc} entries
module prefetch_fifo
  import instr_prefetch_queue_pkg::*;
#(
  parameter int W     = WORD_W + ADDR_W,
  parameter int DEPTH = 4,
  parameter int CW    = count_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [W-1:0]  last_q;
  logic          full;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Head entry is read combinationally; while empty the last shown entry is held
  assign rd_data = empty ? last_q : mem[rd_ptr];

  // Entry storage: written only on an accepted push
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; clear (redirect) empties the queue like reset does
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Remember the most recently presented head so the output is stable when empty
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
    end else if (!empty) begin
      last_q <= mem[rd_ptr];
    end
  end

  // The fetch credit scheme must never present a push to a full queue
  always_ff @(posedge clk) begin
    if (!rst && !clear) begin
      assert (!(push && full));
    end
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - instruction fetch stage with credit-limited prefetch queue
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
#(
  parameter int              AW       = ADDR_W,
  parameter int              DW       = WORD_W,
  parameter int              DEPTH    = 4,
  parameter logic [AW-1:0]   RESET_PC = PROC_RESET_PC
) (
  input logic                   clk,
  input logic                   reset,
  instr_prefetch_queue_if.master bus
);

  localparam int CW = count_width(DEPTH);

  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] req_pc;
  logic          inflight;
  logic [CW-1:0] count;
  logic          empty;
  logic          issue;
  logic          push;
  logic          pop;
  logic [CW:0]   credit_used;
  logic [DW+AW-1:0] head;

  // Entries held plus the response still on its way back from memory
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};

  assign issue = !reset && !bus.redirect && (credit_used < (CW+1)'(DEPTH));
  assign push  = inflight && !bus.redirect;
  assign pop   = !empty && bus.instr_ready && !bus.redirect;

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = fetch_pc;
  assign bus.instr_valid = !empty;
  assign bus.instr_data  = head[DW+AW-1:AW];
  assign bus.instr_pc    = head[AW-1:0];
  assign bus.q_count     = count;

  // Fetch address, outstanding-request flag and the PC of that request
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (bus.redirect) begin
        fetch_pc <= bus.redirect_pc;
      end else if (issue) begin
        fetch_pc <= fetch_pc + AW'(1);
        req_pc   <= fetch_pc;
      end
    end
  end

  prefetch_fifo #(
    .W     (DW + AW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .clear     (bus.redirect),
    .push      (push),
    .push_data ({bus.imem_rdata, req_pc}),
    .pop       (pop),
    .rd_data   (head),
    .count     (count),
    .empty     (empty)
  );

endmodule
